// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retire-trace recorder: FSM encoding, entry layout
// and the log2 helper used to size pointers and indices.
package trace_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_POST    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Entry layout, LSB first: pc, wdata, inst, rd, regwe.
  function automatic int ent_w(input int xlen);
    return 2 * xlen + 38;
  endfunction

  function automatic int off_wdata(input int xlen);
    return xlen;
  endfunction

  function automatic int off_inst(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int off_rd(input int xlen);
    return 2 * xlen + 32;
  endfunction

  function automatic int off_regwe(input int xlen);
    return 2 * xlen + 37;
  endfunction

  function automatic int idx_w(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Capture tap and readback bus of the retire-trace recorder.
// Readback: rd_req sampled on a rising edge yields rd_valid/rd_data for the
// following cycle only; there is no ready, the requester must accept it then.
interface retire_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  import trace_pkg::*;

  localparam int IW = idx_w(DEPTH);
  localparam int EW = ent_w(XLEN);

  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_inst;
  logic [4:0]      cap_rd;
  logic [XLEN-1:0] cap_wdata;
  logic            cap_regwe;
  logic            rd_req;
  logic [IW-1:0]   rd_idx;
  logic            rd_valid;
  logic [EW-1:0]   rd_data;

  modport master (
    output cap_valid, cap_pc, cap_inst, cap_rd, cap_wdata, cap_regwe,
    output rd_req, rd_idx,
    input  rd_valid, rd_data
  );

  modport slave (
    input  cap_valid, cap_pc, cap_inst, cap_rd, cap_wdata, cap_regwe,
    input  rd_req, rd_idx,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/retire_trace_buffer_ram.sv
// Single-write, single-registered-read entry store. A read of the slot being
// written in the same cycle returns the previous contents.
module trace_ram #(
  parameter int W     = 102,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-trace recorder: circular history of retired instructions with an
// optional PC-match trigger that stops capture POST_TRIG entries later.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  retire_trace_buffer_if.slave bus,
  input  logic                 arm,
  input  logic                 trig_en,
  input  logic [XLEN-1:0]      trig_pc,
  output logic [idx_w(DEPTH):0] count,
  output logic                 overflow,
  output logic                 trig_hit,
  output logic [1:0]           state
);

  localparam int IW = idx_w(DEPTH);
  localparam int EW = ent_w(XLEN);

  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] post_cnt;
  logic [IW-1:0] rd_addr;
  logic          wr_en;
  logic          trig_fire;
  logic          rd_valid_q;
  logic          rd_blank;
  logic [EW-1:0] wr_word;
  logic [EW-1:0] ram_q;

  always_comb begin
    wr_en     = !rst && !arm && bus.cap_valid &&
                (state == ST_CAPTURE || state == ST_POST);
    trig_fire = wr_en && (state == ST_CAPTURE) && trig_en && (bus.cap_pc == trig_pc);
    wr_word   = {bus.cap_regwe, bus.cap_rd, bus.cap_inst, bus.cap_wdata, bus.cap_pc};
    // Once wrapped, the oldest entry is the one about to be overwritten.
    rd_addr   = (overflow ? wr_ptr : '0) + bus.rd_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      post_cnt   <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      trig_hit   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_blank   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      rd_blank   <= ({1'b0, bus.rd_idx} >= count);
      if (arm) begin
        state    <= ST_CAPTURE;
        wr_ptr   <= '0;
        post_cnt <= '0;
        count    <= '0;
        overflow <= 1'b0;
        trig_hit <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == (IW+1)'(DEPTH)) overflow <= 1'b1;
        else                         count    <= count + 1'b1;
        if (trig_fire) begin
          trig_hit <= 1'b1;
          if (POST_TRIG == 0) begin
            state <= ST_DONE;
          end else begin
            post_cnt <= IW'(POST_TRIG);
            state    <= ST_POST;
          end
        end else if (state == ST_POST) begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == IW'(1)) state <= ST_DONE;
        end
      end
    end
  end

  trace_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .re    (bus.rd_req),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = (rd_valid_q && !rd_blank) ? ram_q : '0;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: two instances (POST_TRIG=8 and 0)
// share one stimulus stream; each scenario task checks its own results.
module tb_retire_trace_buffer;
  import trace_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int EW    = 2 * XLEN + 38;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            cap_valid = 1'b0;
  logic [XLEN-1:0] cap_pc    = '0;
  logic [31:0]     cap_inst  = '0;
  logic [4:0]      cap_rd    = '0;
  logic [XLEN-1:0] cap_wdata = '0;
  logic            cap_regwe = 1'b0;
  logic            rd_req    = 1'b0;
  logic [3:0]      rd_idx    = '0;
  logic            arm       = 1'b0;
  logic            trig_en   = 1'b0;
  logic [XLEN-1:0] trig_pc   = '0;

  logic [4:0] count, count0;
  logic       overflow, overflow0, trig_hit, trig_hit0;
  logic [1:0] state, state0;

  retire_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  retire_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus0 ();

  assign bus.cap_valid  = cap_valid;  assign bus0.cap_valid  = cap_valid;
  assign bus.cap_pc     = cap_pc;     assign bus0.cap_pc     = cap_pc;
  assign bus.cap_inst   = cap_inst;   assign bus0.cap_inst   = cap_inst;
  assign bus.cap_rd     = cap_rd;     assign bus0.cap_rd     = cap_rd;
  assign bus.cap_wdata  = cap_wdata;  assign bus0.cap_wdata  = cap_wdata;
  assign bus.cap_regwe  = cap_regwe;  assign bus0.cap_regwe  = cap_regwe;
  assign bus.rd_req     = rd_req;     assign bus0.rd_req     = rd_req;
  assign bus.rd_idx     = rd_idx;     assign bus0.rd_idx     = rd_idx;

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .count(count), .overflow(overflow), .trig_hit(trig_hit), .state(state)
  );

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .count(count0), .overflow(overflow0), .trig_hit(trig_hit0), .state(state0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  // Stimulus pattern: every field of an entry is derived from its PC.
  function automatic logic [EW-1:0] mk_entry(input logic [31:0] pc);
    logic [31:0] wd;
    wd = pc * 32'd3 + 32'd1;
    return {pc[2], pc[6:2], 32'h0010_0093 ^ pc, wd, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [31:0] pc);
    logic [EW-1:0] e;
    e = mk_entry(pc);
    cap_valid = 1'b1;
    cap_pc    = e[31:0];
    cap_wdata = e[63:32];
    cap_inst  = e[95:64];
    cap_rd    = e[100:96];
    cap_regwe = e[101];
  endtask

  task automatic do_retire(input logic [31:0] pc);
    drive_entry(pc);
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] idx, output logic v, output logic [EW-1:0] d);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    v = bus.rd_valid;
    d = bus.rd_data;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (overflow !== 1'b0 || trig_hit !== 1'b0) begin n_fail++; $display("FAIL reset_flags got ovf=%b hit=%b exp 0 0", overflow, trig_hit); end
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd got v=%b d=%h exp 0 0", bus.rd_valid, bus.rd_data); end
    n_checks++; if (state0 !== ST_IDLE || count0 !== 5'd0) begin n_fail++; $display("FAIL reset_dut0 got st=%0d cnt=%0d exp 0 0", state0, count0); end
    rst = 1'b0;
    do_retire(32'h40);
    n_checks++; if (count !== 5'd0 || state !== ST_IDLE) begin n_fail++; $display("FAIL idle_ignore got cnt=%0d st=%0d exp 0 0", count, state); end
  endtask

  task automatic test_basic();
    logic v;
    logic [EW-1:0] d;
    trig_en = 1'b0;
    do_arm();
    n_checks++; if (state !== ST_CAPTURE) begin n_fail++; $display("FAIL arm_state got %0d exp 1", state); end
    for (int k = 0; k < 5; k++) do_retire(32'(4 * k));
    n_checks++; if (count !== 5'd5 || overflow !== 1'b0) begin n_fail++; $display("FAIL basic_count got cnt=%0d ovf=%b exp 5 0", count, overflow); end
    for (int k = 0; k < 5; k++) begin
      do_read(4'(k), v, d);
      n_checks++;
      if (v !== 1'b1 || d !== mk_entry(32'(4 * k))) begin
        n_fail++; $display("FAIL basic_read%0d got v=%b d=%h exp 1 %h", k, v, d, mk_entry(32'(4 * k)));
      end
    end
    tick();
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin n_fail++; $display("FAIL rd_drop got v=%b d=%h exp 0 0", bus.rd_valid, bus.rd_data); end
    do_read(4'd7, v, d);
    n_checks++; if (v !== 1'b1 || d !== '0) begin n_fail++; $display("FAIL read_beyond got v=%b d=%h exp 1 0", v, d); end
  endtask

  task automatic test_wrap();
    logic v;
    logic [EW-1:0] d;
    logic [EW-1:0] e;
    exp_q.delete();
    do_arm();
    for (int k = 0; k < 20; k++) begin
      do_retire(32'(4 * k));
      exp_q.push_back(mk_entry(32'(4 * k)));
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      if (k == 15) begin
        n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got cnt=%0d ovf=%b exp 16 0", count, overflow); end
      end
      if (k == 16) begin
        n_checks++; if (count !== 5'd16 || overflow !== 1'b1) begin n_fail++; $display("FAIL first_ovf got cnt=%0d ovf=%b exp 16 1", count, overflow); end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      do_read(4'(k), v, d);
      e = exp_q[k];
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL wrap_read%0d got v=%b pc=%h exp 1 %h", k, v, d[31:0], e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_idx = 4'(15 - k);
      tick();
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data[31:0] !== 32'(76 - 4 * k)) begin
        n_fail++; $display("FAIL b2b_read%0d got v=%b pc=%h exp 1 %h", k, bus.rd_valid, bus.rd_data[31:0], 32'(76 - 4 * k));
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_trigger();
    logic v;
    logic [EW-1:0] d;
    trig_en = 1'b1;
    trig_pc = 32'h20;
    do_arm();
    for (int k = 0; k <= 24; k++) begin
      do_retire(32'(4 * k));
      if (k == 8) begin
        n_checks++; if (state !== ST_POST || trig_hit !== 1'b1) begin n_fail++; $display("FAIL trig_fire got st=%0d hit=%b exp 2 1", state, trig_hit); end
      end
      if (k == 15) begin
        n_checks++; if (state !== ST_POST) begin n_fail++; $display("FAIL post_hold got %0d exp 2", state); end
      end
      if (k == 16) begin
        n_checks++; if (state !== ST_DONE) begin n_fail++; $display("FAIL post_done got %0d exp 3", state); end
      end
    end
    n_checks++; if (count !== 5'd16 || overflow !== 1'b1 || trig_hit !== 1'b1) begin n_fail++; $display("FAIL trig_final got cnt=%0d ovf=%b hit=%b exp 16 1 1", count, overflow, trig_hit); end
    do_read(4'd15, v, d);
    n_checks++; if (d[31:0] !== 32'h40) begin n_fail++; $display("FAIL trig_newest got %h exp 40", d[31:0]); end
    do_read(4'd0, v, d);
    n_checks++; if (d[31:0] !== 32'h04) begin n_fail++; $display("FAIL trig_oldest got %h exp 4", d[31:0]); end
  endtask

  task automatic test_arm_in_done();
    logic v;
    logic [EW-1:0] d;
    trig_en = 1'b0;
    arm = 1'b1;
    drive_entry(32'h100);
    tick();
    arm = 1'b0;
    cap_valid = 1'b0;
    n_checks++; if (count !== 5'd0 || state !== ST_CAPTURE || overflow !== 1'b0 || trig_hit !== 1'b0) begin
      n_fail++; $display("FAIL arm_priority got cnt=%0d st=%0d ovf=%b hit=%b exp 0 1 0 0", count, state, overflow, trig_hit);
    end
    do_retire(32'h200);
    do_read(4'd0, v, d);
    n_checks++; if (count !== 5'd1 || d !== mk_entry(32'h200)) begin n_fail++; $display("FAIL arm_first got cnt=%0d pc=%h exp 1 200", count, d[31:0]); end
  endtask

  task automatic test_post_zero();
    logic [EW-1:0] d;
    trig_en = 1'b1;
    trig_pc = 32'h8;
    do_arm();
    do_retire(32'h0);
    do_retire(32'h4);
    n_checks++; if (state0 !== ST_CAPTURE) begin n_fail++; $display("FAIL p0_before got %0d exp 1", state0); end
    do_retire(32'h8);
    n_checks++; if (state0 !== ST_DONE || count0 !== 5'd3 || trig_hit0 !== 1'b1) begin n_fail++; $display("FAIL p0_done got st=%0d cnt=%0d hit=%b exp 3 3 1", state0, count0, trig_hit0); end
    do_retire(32'hc);
    do_retire(32'h10);
    n_checks++; if (count0 !== 5'd3 || state0 !== ST_DONE) begin n_fail++; $display("FAIL p0_ignore got cnt=%0d st=%0d exp 3 3", count0, state0); end
    rd_req = 1'b1;
    rd_idx = 4'd2;
    tick();
    d = bus0.rd_data;
    rd_req = 1'b0;
    n_checks++; if (d[31:0] !== 32'h8) begin n_fail++; $display("FAIL p0_read got %h exp 8", d[31:0]); end
  endtask

  task automatic test_reset_mid_post();
    trig_en = 1'b1;
    trig_pc = 32'h0;
    do_arm();
    do_retire(32'h0);
    do_retire(32'h4);
    n_checks++; if (state !== ST_POST || count !== 5'd2) begin n_fail++; $display("FAIL pre_rst got st=%0d cnt=%0d exp 2 2", state, count); end
    rst = 1'b1;
    rd_req = 1'b1;
    drive_entry(32'h8);
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    cap_valid = 1'b0;
    n_checks++; if (state !== ST_IDLE || count !== 5'd0 || bus.rd_valid !== 1'b0 || trig_hit !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst got st=%0d cnt=%0d v=%b hit=%b ovf=%b exp 0 0 0 0 0", state, count, bus.rd_valid, trig_hit, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_trigger();
    test_arm_in_done();
    test_post_zero();
    test_reset_mid_post();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
